matmul_apb_requester: RTL

- APB requester (master) that drives the matmul accelerator's APB completer port: register loads, operand writes, start and flags writes, and scratchpad/result reads.
- Sits between a testbench or firmware-style sequencer and the DUT APB slave.
- Queues commands in a small FIFO and runs them as strict SETUP/ACCESS APB transfers.
- Returns one response per command, with a wait-state timeout guard.

---
 rtl/matmul_apb_requester.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/matmul_apb_requester.sv
// -----------------------------------------------------------------------------
// matmul_apb_requester
//   APB requester for the matmul accelerator's completer port. Commands
//   (register loads, operand writes, start/flags writes, scratchpad/result
//   reads) are queued in a small FIFO. Each one runs as a strict SETUP/ACCESS
//   transfer, and each one returns exactly one response. Only one transfer is
//   outstanding at a time. A wait-state timeout aborts a stalled ACCESS phase.
//
// Ports
//   clk_i, rst_ni         clock (rising edge), synchronous active-low reset
//   cmd_*                 command push side (valid/ready, write, addr, wdata, strb)
//   psel_o .. pstrb_o     APB request signals (registered)
//   prdata_i, pready_i,
//   pslverr_i             APB completer response
//   rsp_*                 response side (valid/ready, rdata, err, timeout)
//   busy_o                FIFO non-empty or a transfer in progress
// -----------------------------------------------------------------------------
module matmul_apb_requester #(
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]    cmd_wdata_i,
  input  logic [BUS_WIDTH/8-1:0]  cmd_strb_i,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [BUS_WIDTH-1:0]    pwdata_o,
  output logic [BUS_WIDTH/8-1:0]  pstrb_o,
  input  logic [BUS_WIDTH-1:0]    prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [BUS_WIDTH-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic                    busy_o
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

  // Command FIFO storage (data only, never reset)
  logic                  fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [BUS_WIDTH-1:0]  fifo_wdata [FIFO_DEPTH];
  logic [STRB_W-1:0]     fifo_strb  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] wait_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  // A full FIFO refuses the push even if a pop happens on the same edge.
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  // The FSM takes the head in IDLE, or in RESP once the response is consumed.
  assign pop         = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready_i));
  assign busy_o      = (state != IDLE) || !empty;

  // ---- FIFO storage write ----
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write_i;
      fifo_addr[wr_ptr]  <= cmd_addr_i;
      fifo_wdata[wr_ptr] <= cmd_wdata_i;
      fifo_strb[wr_ptr]  <= cmd_strb_i;
    end
  end

  // ---- FIFO control ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- APB transfer FSM with registered outputs ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            psel_o <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt  <= '0;
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_err_o     <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            state         <= RESP;
          end else if (TMO_EN && (wait_cnt == TMR_LAST)) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TMR_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (pop) begin
              // Back-to-back: skip IDLE and go straight into the next SETUP.
              psel_o <= 1'b1;
              state  <= SETUP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // The popped head is loaded into the APB request registers; reads
      // carry zero data and zero strobes.
      if (pop) begin
        pwrite_o <= fifo_write[rd_ptr];
        paddr_o  <= fifo_addr[rd_ptr];
        pwdata_o <= fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
        pstrb_o  <= fifo_write[rd_ptr] ? fifo_strb[rd_ptr]  : '0;
      end
    end
  end

endmodule
